// File: rtl/llc_req_arbiter.sv
// LLC front-end scheduler: merges the CPU and snoop request streams into one command slot.
// Define LLC_ARB_STATS_EN to build the per-source grant counters.
//
// state | meaning
// RUN   | normal arbitration, snoops preferred, starvation limiter active
// DRAIN | clear latched; intake closed, buffered snoops still issue
// CLR   | clear command held in the slot until the LLC takes it
module llc_req_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int OP_W         = 4,
  parameter int SNP_DEPTH    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_valid,
  output logic                         cpu_ready,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [OP_W-1:0]              cpu_op,
  input  logic                         snp_valid,
  output logic                         snp_ready,
  input  logic [ADDR_W-1:0]            snp_addr,
  input  logic [OP_W-1:0]              snp_op,
  output logic                         cmd_valid,
  output logic [ADDR_W-1:0]            cmd_addr,
  output logic [OP_W-1:0]              cmd_op,
  input  logic                         llc_ready,
  output logic                         op_err,
  output logic [$clog2(SNP_DEPTH):0]   snp_count,
  output logic [31:0]                  cpu_grants,
  output logic [31:0]                  snp_grants
);

  localparam int PTR_W = $clog2(SNP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(SNP_DEPTH);
  localparam logic [OP_W-1:0]  OP_CLR    = OP_W'(8);

  typedef enum logic [1:0] {RUN, DRAIN, CLR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fifo_addr [SNP_DEPTH];
  logic [OP_W-1:0]     fifo_op   [SNP_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [STV_W-1:0]    starve;

  logic slot_free;
  logic fifo_empty;
  logic fifo_full;
  logic cpu_wins;
  logic cpu_take;
  logic cpu_issue_ok;
  logic cpu_is_clr;
  logic snp_legal;
  logic snp_take;
  logic push;
  logic pop;
  logic clr_load;

  function automatic logic is_cpu_issue(input logic [OP_W-1:0] op);
    return (op == OP_W'(0)) || (op == OP_W'(1)) || (op == OP_W'(2)) || (op == OP_W'(9));
  endfunction

  function automatic logic is_snp_op(input logic [OP_W-1:0] op);
    return (op == OP_W'(3)) || (op == OP_W'(4)) || (op == OP_W'(5)) || (op == OP_W'(6));
  endfunction

  assign slot_free    = !cmd_valid || llc_ready;
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FIFO_FULL);
  assign cpu_wins     = cpu_valid && (fifo_empty || (starve == STV_MAX));
  assign cpu_take     = (state == RUN) && slot_free && cpu_wins;
  assign cpu_issue_ok = is_cpu_issue(cpu_op);
  assign cpu_is_clr   = (cpu_op == OP_CLR);
  assign snp_legal    = is_snp_op(snp_op);
  assign pop          = slot_free && !fifo_empty &&
                        (((state == RUN) && !cpu_wins) || (state == DRAIN));
  assign snp_ready    = (state == RUN) && (!fifo_full || pop);
  assign snp_take     = snp_valid && snp_ready;
  assign push         = snp_take && snp_legal;
  // The clear goes out only once every snoop ahead of it has left the slot.
  assign clr_load     = (state == DRAIN) && slot_free && fifo_empty;

  assign cpu_ready = cpu_take;
  assign snp_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= snp_addr;
      fifo_op[wr_ptr]   <= snp_op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_op    <= '0;
      starve    <= '0;
      op_err    <= 1'b0;
    end else begin
      op_err <= (cpu_take && !cpu_issue_ok && !cpu_is_clr) || (snp_take && !snp_legal);
      case (state)
        RUN: begin
          if (slot_free) begin
            cmd_valid <= 1'b0;
            if (cpu_wins) begin
              if (cpu_issue_ok) begin
                cmd_valid <= 1'b1;
                cmd_addr  <= cpu_addr;
                cmd_op    <= cpu_op;
                starve    <= '0;
              end else if (cpu_is_clr) begin
                state <= DRAIN;
              end
            end else if (!fifo_empty) begin
              cmd_valid <= 1'b1;
              cmd_addr  <= fifo_addr[rd_ptr];
              cmd_op    <= fifo_op[rd_ptr];
              if (cpu_valid && (starve != STV_MAX)) starve <= starve + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (slot_free) begin
            cmd_valid <= 1'b1;
            if (!fifo_empty) begin
              cmd_addr <= fifo_addr[rd_ptr];
              cmd_op   <= fifo_op[rd_ptr];
            end else begin
              cmd_addr <= '0;
              cmd_op   <= OP_CLR;
              state    <= CLR;
            end
          end
        end
        CLR: begin
          if (llc_ready) begin
            cmd_valid <= 1'b0;
            starve    <= '0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef LLC_ARB_STATS_EN
  logic        cpu_load;
  logic [31:0] cpu_grant_q;
  logic [31:0] snp_grant_q;

  assign cpu_load = (cpu_take && cpu_issue_ok) || clr_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_grant_q <= '0;
      snp_grant_q <= '0;
    end else begin
      if (cpu_load) cpu_grant_q <= cpu_grant_q + 32'd1;
      if (pop)      snp_grant_q <= snp_grant_q + 32'd1;
    end
  end

  assign cpu_grants = cpu_grant_q;
  assign snp_grants = snp_grant_q;
`else
  assign cpu_grants = '0;
  assign snp_grants = '0;
`endif

endmodule

// File: tb/tb_llc_req_arbiter.sv
// Scoreboard bench for llc_req_arbiter: expected commands are queued as stimulus is driven
// and checked in order as the LLC consumes them.
module tb_llc_req_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [31:0] cpu_addr = '0;
  logic [3:0]  cpu_op = '0;
  logic        snp_valid = 1'b0;
  logic        snp_ready;
  logic [31:0] snp_addr = '0;
  logic [3:0]  snp_op = '0;
  logic        cmd_valid;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_op;
  logic        llc_ready = 1'b0;
  logic        op_err;
  logic [2:0]  snp_count;
  logic [31:0] cpu_grants;
  logic [31:0] snp_grants;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  op;
    bit          src_cpu;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   fails = 0;
  int   pop_cpu = 0;
  int   pop_snp = 0;
  bit   s_cpu_acc, s_snp_acc, s_cpu_ready, s_snp_ready, s_pop;
  logic [3:0] s_pop_op;

  llc_req_arbiter #(.ADDR_W(32), .OP_W(4), .SNP_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_op(cpu_op),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_addr(snp_addr), .snp_op(snp_op),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_op(cmd_op), .llc_ready(llc_ready),
    .op_err(op_err), .snp_count(snp_count), .cpu_grants(cpu_grants), .snp_grants(snp_grants)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  function automatic void push_exp(input logic [31:0] a, input logic [3:0] o, input bit c);
    exp_t e;
    e.addr = a; e.op = o; e.src_cpu = c;
    exp_q.push_back(e);
  endfunction

  // One clock: sample handshakes at the falling edge, score any consumed command, return #1 after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_cpu_acc   = cpu_valid && cpu_ready;
    s_snp_acc   = snp_valid && snp_ready;
    s_cpu_ready = cpu_ready;
    s_snp_ready = snp_ready;
    s_pop       = cmd_valid && llc_ready;
    s_pop_op    = cmd_op;
    if (s_pop) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got op=%0d addr=%h, expected no command", cmd_op, cmd_addr);
      end else begin
        e = exp_q.pop_front();
        if (cmd_op !== e.op || cmd_addr !== e.addr) begin
          fails++;
          $display("FAIL sb_order: got op=%0d addr=%h, expected op=%0d addr=%h", cmd_op, cmd_addr, e.op, e.addr);
        end
        if (e.src_cpu) pop_cpu++; else pop_snp++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d commands still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
    tests_run++; if (cmd_addr !== 32'h0) begin fails++; $display("FAIL reset_cmd_addr: got %h expected 0", cmd_addr); end
    tests_run++; if (cmd_op !== 4'h0) begin fails++; $display("FAIL reset_cmd_op: got %0d expected 0", cmd_op); end
    tests_run++; if (op_err !== 1'b0) begin fails++; $display("FAIL reset_op_err: got %b expected 0", op_err); end
    tests_run++; if (snp_count !== 3'd0) begin fails++; $display("FAIL reset_snp_count: got %0d expected 0", snp_count); end
    tests_run++; if (cpu_grants !== 32'd0 || snp_grants !== 32'd0) begin fails++; $display("FAIL reset_grants: got %0d/%0d expected 0/0", cpu_grants, snp_grants); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++; if (snp_ready !== 1'b1) begin fails++; $display("FAIL reset_snp_ready: got %b expected 1", snp_ready); end
  endtask

  task automatic test_cpu_basic();
    llc_ready = 1'b1;
    cpu_valid = 1'b1; cpu_op = 4'd0; cpu_addr = 32'h0000_1040;
    push_exp(32'h0000_1040, 4'd0, 1'b1);
    tick();
    cpu_valid = 1'b0;
    tests_run++; if (!s_cpu_acc) begin fails++; $display("FAIL basic_accept: got cpu_ready=%b expected 1", s_cpu_ready); end
    tests_run++; if (cmd_valid !== 1'b1) begin fails++; $display("FAIL basic_cmd_valid: got %b expected 1", cmd_valid); end
    tests_run++; if (cmd_op !== 4'd0 || cmd_addr !== 32'h0000_1040) begin fails++; $display("FAIL basic_cmd: got op=%0d addr=%h expected op=0 addr=00001040", cmd_op, cmd_addr); end
    tests_run++; if (snp_count !== 3'd0) begin fails++; $display("FAIL basic_snp_count: got %0d expected 0", snp_count); end
    cpu_valid = 1'b1; cpu_op = 4'd9; cpu_addr = 32'h0000_2000;
    push_exp(32'h0000_2000, 4'd9, 1'b1);
    tick();
    cpu_valid = 1'b0;
    tests_run++; if (cmd_valid !== 1'b1 || cmd_op !== 4'd9) begin fails++; $display("FAIL basic_print: got valid=%b op=%0d expected valid=1 op=9", cmd_valid, cmd_op); end
    drain("basic");
  endtask

  task automatic test_starvation();
    bit got = 1'b0;
    llc_ready = 1'b0;
    cpu_valid = 1'b1; cpu_op = 4'd0; cpu_addr = 32'h0000_0100;
    push_exp(32'h0000_0100, 4'd0, 1'b1);
    tick();
    cpu_valid = 1'b0;
    push_exp(32'h0000_0300, 4'd3, 1'b0);
    push_exp(32'h0000_0400, 4'd4, 1'b0);
    push_exp(32'h0000_0500, 4'd5, 1'b0);
    push_exp(32'h0000_1000, 4'd1, 1'b1);
    push_exp(32'h0000_0600, 4'd6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      snp_valid = 1'b1; snp_op = 4'(3 + i); snp_addr = 32'h0000_0300 + 32'(i) * 32'h100;
      tick();
      tests_run++; if (!s_snp_acc) begin fails++; $display("FAIL starve_push%0d: got snp_ready=%b expected 1", i, s_snp_ready); end
    end
    snp_valid = 1'b1; snp_op = 4'd3; snp_addr = 32'h0000_0BAD;
    cpu_valid = 1'b1; cpu_op = 4'd1; cpu_addr = 32'h0000_1000;
    tick();
    tests_run++; if (s_snp_ready) begin fails++; $display("FAIL starve_full_ready: got snp_ready=%b expected 0", s_snp_ready); end
    tests_run++; if (snp_count !== 3'd4) begin fails++; $display("FAIL starve_full_count: got %0d expected 4", snp_count); end
    snp_valid = 1'b0;
    llc_ready = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (s_cpu_acc) begin
        got = 1'b1;
        cpu_valid = 1'b0;
      end
    end
    cpu_valid = 1'b0;
    tests_run++; if (!got) begin fails++; $display("FAIL starve_cpu_accept: got no acceptance expected one within 10 cycles"); end
    drain("starve");
  endtask

  task automatic test_stall();
    int k = 0;
    llc_ready = 1'b0;
    cpu_valid = 1'b1; cpu_op = 4'd2; cpu_addr = 32'h0000_2222;
    push_exp(32'h0000_2222, 4'd2, 1'b1);
    tick();
    cpu_op = 4'd1; cpu_addr = 32'h0000_3333;
    snp_valid = 1'b1; snp_op = 4'd3; snp_addr = 32'h0000_4000;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_snp_acc) begin
        push_exp(snp_addr, snp_op, 1'b0);
        k++;
        snp_op = 4'(3 + (k % 4)); snp_addr = 32'h0000_4000 + 32'(k) * 32'h10;
      end
      tests_run++; if (cmd_valid !== 1'b1 || cmd_op !== 4'd2 || cmd_addr !== 32'h0000_2222) begin fails++; $display("FAIL stall_hold%0d: got valid=%b op=%0d addr=%h expected 1/2/00002222", i, cmd_valid, cmd_op, cmd_addr); end
      tests_run++; if (s_cpu_ready) begin fails++; $display("FAIL stall_cpu_ready%0d: got %b expected 0", i, s_cpu_ready); end
      tests_run++; if (snp_count !== 3'((i < 3) ? i + 1 : 4)) begin fails++; $display("FAIL stall_count%0d: got %0d expected %0d", i, snp_count, (i < 3) ? i + 1 : 4); end
    end
    tests_run++; if (k != 4) begin fails++; $display("FAIL stall_pushes: got %0d expected 4", k); end
    cpu_valid = 1'b0; snp_valid = 1'b0;
    llc_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_clear();
    bit acc = 1'b0;
    bit done = 1'b0;
    llc_ready = 1'b0;
    cpu_valid = 1'b1; cpu_op = 4'd0; cpu_addr = 32'h0000_0500;
    push_exp(32'h0000_0500, 4'd0, 1'b1);
    tick();
    cpu_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      snp_valid = 1'b1; snp_op = 4'(5 + i); snp_addr = 32'h0000_5100 + 32'(i) * 32'h100;
      tick();
      if (s_snp_acc) push_exp(snp_addr, snp_op, 1'b0);
    end
    snp_valid = 1'b0;
    cpu_valid = 1'b1; cpu_op = 4'd8; cpu_addr = 32'h0000_7777;
    push_exp(32'h0000_0000, 4'd8, 1'b1);
    llc_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (acc) begin
        tests_run++; if (s_cpu_ready || s_snp_ready) begin fails++; $display("FAIL clear_ready_closed: got cpu_ready=%b snp_ready=%b expected 0/0", s_cpu_ready, s_snp_ready); end
        if (s_pop && s_pop_op == 4'd8) done = 1'b1;
      end else if (s_cpu_acc) begin
        acc = 1'b1;
        cpu_op = 4'd1; cpu_addr = 32'h0000_8888;
        snp_valid = 1'b1; snp_op = 4'd3; snp_addr = 32'h0000_9999;
      end
    end
    cpu_valid = 1'b0; snp_valid = 1'b0;
    tests_run++; if (!(acc && done)) begin fails++; $display("FAIL clear_sequence: got accepted=%b consumed=%b expected 1/1", acc, done); end
    drain("clear");
  endtask

  task automatic test_op_err();
    logic [31:0] exp_cg, exp_sg;
    llc_ready = 1'b1;
    cpu_valid = 1'b1; cpu_op = 4'd7; cpu_addr = 32'h0000_0007;
    tick();
    cpu_valid = 1'b0;
    tests_run++; if (!s_cpu_acc) begin fails++; $display("FAIL err_cpu_accept: got cpu_ready=%b expected 1", s_cpu_ready); end
    tests_run++; if (op_err !== 1'b1) begin fails++; $display("FAIL err_cpu_pulse: got %b expected 1", op_err); end
    tests_run++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL err_cpu_no_issue: got cmd_valid=%b expected 0", cmd_valid); end
    tick();
    tests_run++; if (op_err !== 1'b0) begin fails++; $display("FAIL err_cpu_pulse_end: got %b expected 0", op_err); end
    snp_valid = 1'b1; snp_op = 4'd2; snp_addr = 32'h0000_0002;
    tick();
    snp_valid = 1'b0;
    tests_run++; if (!s_snp_acc) begin fails++; $display("FAIL err_snp_accept: got snp_ready=%b expected 1", s_snp_ready); end
    tests_run++; if (op_err !== 1'b1) begin fails++; $display("FAIL err_snp_pulse: got %b expected 1", op_err); end
    tests_run++; if (snp_count !== 3'd0) begin fails++; $display("FAIL err_snp_count: got %0d expected 0", snp_count); end
    tick();
    tests_run++; if (op_err !== 1'b0 || cmd_valid !== 1'b0) begin fails++; $display("FAIL err_snp_end: got op_err=%b cmd_valid=%b expected 0/0", op_err, cmd_valid); end
`ifdef LLC_ARB_STATS_EN
    exp_cg = 32'(pop_cpu); exp_sg = 32'(pop_snp);
`else
    exp_cg = 32'd0; exp_sg = 32'd0;
`endif
    tests_run++; if (cpu_grants !== exp_cg || snp_grants !== exp_sg) begin fails++; $display("FAIL err_grants: got %0d/%0d expected %0d/%0d", cpu_grants, snp_grants, exp_cg, exp_sg); end
  endtask

  task automatic test_reset_mid();
    bit acc = 1'b0;
    int k = 0;
    logic [31:0] exp_cg;
    llc_ready = 1'b0;
    cpu_valid = 1'b1; cpu_op = 4'd0; cpu_addr = 32'h0000_A000;
    push_exp(32'h0000_A000, 4'd0, 1'b1);
    tick();
    cpu_op = 4'd8; cpu_addr = 32'h0;
    snp_valid = 1'b1; snp_op = 4'd3; snp_addr = 32'h0000_B000;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_snp_acc) begin
        push_exp(snp_addr, snp_op, 1'b0);
        k++;
        snp_op = 4'(3 + (k % 4)); snp_addr = 32'h0000_B000 + 32'(k) * 32'h10;
      end
    end
    tests_run++; if (k != 4) begin fails++; $display("FAIL rst_fill: got %0d pushes expected 4", k); end
    llc_ready = 1'b1;
    for (int i = 0; i < 10 && !acc; i++) begin
      tick();
      if (s_snp_acc) begin
        push_exp(snp_addr, snp_op, 1'b0);
        k++;
        snp_op = 4'(3 + (k % 4)); snp_addr = 32'h0000_B000 + 32'(k) * 32'h10;
        if (k == 6) snp_valid = 1'b0;
      end
      if (s_cpu_acc) acc = 1'b1;
    end
    cpu_valid = 1'b0; snp_valid = 1'b0;
    tests_run++; if (!acc || snp_count !== 3'd3) begin fails++; $display("FAIL rst_drain_setup: got accepted=%b count=%0d expected 1/3", acc, snp_count); end
    reset = 1'b1;
    #1;
    exp_q.delete();
    pop_cpu = 0; pop_snp = 0;
    tests_run++; if (cmd_valid !== 1'b0 || cmd_op !== 4'd0 || cmd_addr !== 32'h0) begin fails++; $display("FAIL rst_mid_cmd: got %b/%0d/%h expected 0/0/0", cmd_valid, cmd_op, cmd_addr); end
    tests_run++; if (snp_count !== 3'd0 || op_err !== 1'b0) begin fails++; $display("FAIL rst_mid_fifo: got count=%0d op_err=%b expected 0/0", snp_count, op_err); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++; if (snp_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_state: got snp_ready=%b expected 1", snp_ready); end
    cpu_valid = 1'b1; cpu_op = 4'd2; cpu_addr = 32'h0000_C0DE;
    push_exp(32'h0000_C0DE, 4'd2, 1'b1);
    tick();
    cpu_valid = 1'b0;
    tests_run++; if (cmd_valid !== 1'b1 || cmd_op !== 4'd2 || cmd_addr !== 32'h0000_C0DE) begin fails++; $display("FAIL rst_after_issue: got %b/%0d/%h expected 1/2/0000c0de", cmd_valid, cmd_op, cmd_addr); end
    drain("rst_after");
`ifdef LLC_ARB_STATS_EN
    exp_cg = 32'd1;
`else
    exp_cg = 32'd0;
`endif
    tests_run++; if (cpu_grants !== exp_cg || snp_grants !== 32'd0) begin fails++; $display("FAIL rst_grants: got %0d/%0d expected %0d/0", cpu_grants, snp_grants, exp_cg); end
  endtask

  initial begin
    test_reset();
    test_cpu_basic();
    test_starvation();
    test_stall();
    test_clear();
    test_op_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
